add_pipe_core: RTL and testbench

- Two-stage pipelined ripple adder that produces the add_out bus (sum, cout).
- Sits directly upstream of the add_out agent/BFM. Its sum/cout ports connect to the add_out bus signals of the same names.
- Operands enter on a valid/ready handshake. Results leave on a valid/ready handshake with full backpressure.
- Low half is added in stage 1; high half plus the registered mid-carry is added in stage 2.

---
 rtl/add_pipe_core.sv | 123 ++++++++++++
 tb/tb_add_pipe_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_core.sv
// Two-stage pipelined ripple adder: low half in stage 1, high half plus mid-carry in stage 2,
// valid/ready on both sides. Define ADD_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module add_pipe_core #(
    parameter int add_width = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [add_width-1:0] a,
    input  logic [add_width-1:0] b,
    input  logic                 cin,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [add_width-1:0] sum,
    output logic                 cout,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int h = add_width / 2;

    generate
        if ((add_width < 2) || ((add_width % 2) != 0)) begin : g_bad_width
            $error("add_pipe_core: add_width must be even and >= 2");
        end
    endgenerate

    // Stage 1 state
    logic                 s1_valid_reg;
    logic [h-1:0]         s1_lo_reg;
    logic                 s1_c_reg;
    logic [h-1:0]         s1_ahi_reg;
    logic [h-1:0]         s1_bhi_reg;

    // Stage 2 state (drives the output bus directly)
    logic                 s2_valid_reg;
    logic [add_width-1:0] sum_reg;
    logic                 cout_reg;

    // Ripple chains for both halves
    logic [h:0]           lo_carry;
    logic [h-1:0]         lo_sum;
    logic [h:0]           hi_carry;
    logic [h-1:0]         hi_sum;

    logic                 s2_free;
    logic                 s1_advance;
    logic                 accept;

    assign lo_carry[0] = cin;
    assign hi_carry[0] = s1_c_reg;

    generate
        for (genvar gi = 0; gi < h; gi++) begin : g_ripple
            assign lo_sum[gi]       = a[gi] ^ b[gi] ^ lo_carry[gi];
            assign lo_carry[gi + 1] = (a[gi] & b[gi]) | (lo_carry[gi] & (a[gi] ^ b[gi]));
            assign hi_sum[gi]       = s1_ahi_reg[gi] ^ s1_bhi_reg[gi] ^ hi_carry[gi];
            assign hi_carry[gi + 1] = (s1_ahi_reg[gi] & s1_bhi_reg[gi])
                                    | (hi_carry[gi] & (s1_ahi_reg[gi] ^ s1_bhi_reg[gi]));
        end
    endgenerate

    // Handshake: stage 2 can take a new result if empty or being drained this cycle
    assign s2_free    = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_free;
    assign in_ready   = rst && (!s1_valid_reg || s2_free);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_lo_reg    <= '0;
            s1_c_reg     <= 1'b0;
            s1_ahi_reg   <= '0;
            s1_bhi_reg   <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_lo_reg    <= lo_sum;
            s1_c_reg     <= lo_carry[h];
            s1_ahi_reg   <= a[add_width-1:h];
            s1_bhi_reg   <= b[add_width-1:h];
        end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
        end else if (s1_advance) begin
            s2_valid_reg <= 1'b1;
            sum_reg      <= {hi_sum, s1_lo_reg};
            cout_reg     <= hi_carry[h];
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

`ifdef ADD_PIPE_OVF_EN
    logic ovf_reg;

    // Overflow when both operands share a sign the result does not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (s1_advance) begin
            ovf_reg <= (s1_ahi_reg[h-1] == s1_bhi_reg[h-1]) && (hi_sum[h-1] != s1_ahi_reg[h-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign out_valid = s2_valid_reg;

endmodule

// File: tb/tb_add_pipe_core.sv
// Scoreboard bench for add_pipe_core: stimulus pushes arithmetic expectations, a negedge monitor
// pops and compares each consumed result; ovf is checked when ADD_PIPE_OVF_EN is defined.
module tb_add_pipe_core;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef ADD_PIPE_OVF_EN
    logic         ovf;
`endif

    add_pipe_core #(.add_width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ADD_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] full;
        logic       ovf;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    bit   chk_lat = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t e;
        int   u;
        int   sa;
        int   sbv;
        int   s;
        u   = int'(av) + int'(bv) + int'(cv);
        sa  = (int'(av) >= 2**(W-1)) ? int'(av) - 2**W : int'(av);
        sbv = (int'(bv) >= 2**(W-1)) ? int'(bv) - 2**W : int'(bv);
        s   = sa + sbv + int'(cv);
        e.full    = u[W:0];
        e.ovf     = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
        e.acc_cyc = 0;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            ncyc++;
        end
    end

    // Monitor: compares every consumed result and checks hold stability under backpressure
    initial begin
        bit         hold_prev;
        logic [W:0] prev;
        exp_t       e;
        hold_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'({cout, sum}), 32'(prev));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%0h required=none", {cout, sum});
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'({cout, sum}), 32'(e.full));
`ifdef ADD_PIPE_OVF_EN
                        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                        if (chk_lat) chk("latency", 32'(ncyc - e.acc_cyc), 32'd2);
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev = {cout, sum};
            end
        end
    end

    // One clock: sample handshake at negedge, record accepted operands, return at posedge+1
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready && rst;
        if (acc) begin
            e = model(a, b, cin);
            e.acc_cyc = ncyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int bound);
        bit acc;
        int n;
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < bound) begin
            step(acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted a=%0h b=%0h", av, bv);
        end
    endtask

    task automatic drain(input int bound);
        bit acc;
        int n;
        out_ready = 1'b1;
        in_valid = 1'b0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < bound) begin
            step(acc);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n_acc;
        logic [W-1:0] ops [3];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'({cout, sum}), 32'd0);
        #2 rst = 1'b1;
        #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed sums covering mid-carry 0 and 1
        out_ready = 1'b1;
        chk_lat = 1'b1;
        send(4'h7, 4'h8, 1'b1, 4);
        send(4'hF, 4'hF, 1'b1, 4);
        send(4'h3, 4'h4, 1'b0, 4);
        drain(10);

        // Back-to-back stream: every cycle accepted, every result exactly 2 cycles later
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = W'(i);
            b = W'(i);
            cin = 1'b0;
            step(acc);
            chk("stream_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        drain(10);

        // Backpressure: three operands offered over five stalled cycles
        chk_lat = 1'b0;
        out_ready = 1'b0;
        ops[0] = 4'h1;
        ops[1] = 4'h9;
        ops[2] = 4'hC;
        n_acc = 0;
        in_valid = 1'b1;
        a = ops[0];
        b = ops[0];
        cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            if (acc) begin
                n_acc++;
                a = ops[n_acc];
                b = ops[n_acc];
            end
        end
        chk("stall_accepts", 32'(n_acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step(acc);
        chk("release_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        drain(10);

        // Asynchronous reset with two results in flight
        out_ready = 1'b0;
        send(4'h5, 4'h6, 1'b0, 4);
        send(4'h9, 4'h3, 1'b1, 4);
        step(acc);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'({cout, sum}), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            chk("no_stale_after_rst", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random backpressure and dropped in_valid
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = W'($urandom_range(0, 2**W - 1));
            b = W'($urandom_range(0, 2**W - 1));
            cin = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            step(acc);
        end
        in_valid = 1'b0;
        drain(20);

`ifdef ADD_PIPE_OVF_EN
        chk_lat = 1'b1;
        send(4'h7, 4'h1, 1'b0, 4);
        send(4'h8, 4'h8, 1'b0, 4);
        drain(10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
